// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge control path.
package apb_bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NSLV_DEF   = 3;

    // Bridge controller states; every 3-bit encoding is a named state.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

    // APB SETUP phase: AHB is stalled while the bridge sits here.
    function automatic logic is_setup_state(input apb_state_e s);
        return (s == ST_READ) || (s == ST_WRITE) || (s == ST_WRITEP);
    endfunction

    // APB ENABLE phase: penable high, transfer completes this cycle.
    function automatic logic is_enable_state(input apb_state_e s);
        return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge controller: sequences APB SETUP/ENABLE cycles from the
// pipelined AHB address/data phases and stalls AHB while an access is open.
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NSLV   = NSLV_DEF
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr_d1,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] prdata,
    output logic              pwrite,
    output logic              penable,
    output logic [NSLV-1:0]   psel,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata
);

    apb_state_e        state_q, state_d;
    logic              bad_state;

    logic              pwrite_q, pwrite_d;
    logic              penable_q, penable_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hreadyout_q, hreadyout_d;

    // Next-state selection from the current state and the AHB pipeline view.
    always_comb begin
        state_d   = ST_IDLE;
        bad_state = 1'b0;
        case (state_q)
            // IDLE and the non-pipelined ENABLE states accept a new transfer identically.
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite) begin
                    state_d = ST_READ;
                end else if (valid) begin
                    state_d = ST_WWAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Write data arrives one cycle after the address phase.
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            // Pipelined write: the transfer already captured in the AHB data-phase
            // registers decides what follows.
            ST_WENABLEP: begin
                if (!hwrite_reg) begin
                    state_d = ST_READ;
                end else if (valid) begin
                    state_d = ST_WRITEP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bad_state = 1'b1;
            end
        endcase
    end

    // Output loads chosen by the transition being taken.
    always_comb begin
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        psel_d      = psel_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;
        if (bad_state) begin
            pwrite_d    = 1'b0;
            penable_d   = 1'b0;
            psel_d      = '0;
            paddr_d     = '0;
            pwdata_d    = '0;
            hreadyout_d = 1'b1;
        end else begin
            case (state_d)
                ST_IDLE, ST_WWAIT: begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end
                ST_READ: begin
                    psel_d      = tempselx;
                    // After a pipelined write the read address is already in the data-phase register.
                    paddr_d     = (state_q == ST_WENABLEP) ? haddr_d1 : haddr;
                    pwrite_d    = 1'b0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    psel_d      = tempselx;
                    paddr_d     = haddr_d1;
                    pwdata_d    = hwdata;
                    pwrite_d    = 1'b1;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    penable_d   = 1'b1;
                    hreadyout_d = 1'b1;
                end
                default: begin
                    pwrite_d    = 1'b0;
                    penable_d   = 1'b0;
                    psel_d      = '0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    hreadyout_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered APB/AHB outputs; reset drops any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            psel_q      <= psel_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign penable   = penable_q;
    assign psel      = psel_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;
    assign hrdata    = prdata;

    // APB protocol invariants the controller must never break.
    a_psel_onehot0 : assert property (@(posedge hclk) disable iff (hreset)
        $onehot0(psel_q));
    a_enable_after_select : assert property (@(posedge hclk) disable iff (hreset)
        penable_q |-> ($past(psel_q) != '0));
    a_ready_low_in_setup : assert property (@(posedge hclk) disable iff (hreset)
        hreadyout_q == !is_setup_state(state_q));
    a_enable_in_enable : assert property (@(posedge hclk) disable iff (hreset)
        penable_q == is_enable_state(state_q));

endmodule
